opb_register_ppc2simulink_sync: RTL and testbench

- OPB slave register carrying control words from the PowerPC to user (Simulink) fabric; opposite direction of the simulink2ppc readback registers.
- Software writes a 32-bit word over OPB; the block drives it on `user_data_out` with a one-cycle `user_data_valid` strobe.
- Single clock domain: user logic runs on `OPB_Clk`, so there is no CDC.
- Provides word readback and a write counter for software sanity checks.

---
 rtl/opb_register_ppc2simulink_sync_pkg.sv | 32 +++
 rtl/opb_register_ppc2simulink_sync_if.sv | 26 ++
 rtl/opb_register_ppc2simulink_sync_fsm.sv | 87 ++++++++
 rtl/opb_register_ppc2simulink_sync.sv | 119 +++++++++++
 tb/tb_opb_register_ppc2simulink_sync.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/opb_register_ppc2simulink_sync_pkg.sv
// Shared types and helpers for the OPB register blocks: ack FSM states,
// word offsets, the STATUS signature and the big-endian byte-enable merge.
package opb_reg_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACK     = 2'd1,
      RECOVER = 2'd2
   } opb_state_e;

   localparam logic [1:0]  OFF_DATA   = 2'd0;
   localparam logic [1:0]  OFF_STATUS = 2'd1;
   localparam logic [1:0]  OFF_COMMIT = 2'd2;
   localparam logic [15:0] STATUS_SIG = 16'hA5C3;

   // OPB lane 0 (BE[0]) carries the most significant byte of the word.
   function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                            input logic [31:0] wdata,
                                            input logic [0:3]  be);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            res[31 - 8*i -: 8] = wdata[31 - 8*i -: 8];
         end else begin
            res[31 - 8*i -: 8] = cur[31 - 8*i -: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_sync_if.sv
// OPB slave-side bus bundle; bit 0 is the MSB on every vector, as on the bus.
interface opb_register_ppc2simulink_sync_if;

   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;
   logic [0:31] Sl_DBus;
   logic        Sl_xferAck;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

endinterface

// File: rtl/opb_register_ppc2simulink_sync_fsm.sv
// Reusable OPB slave front end: window decode, IDLE/ACK/RECOVER ack FSM and
// read-data gating so Sl_DBus is zero whenever no ack is driven.
module opb_slave_fsm
   import opb_reg_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h00000000,
   parameter logic [31:0] C_HIGHADDR = 32'h000000FF
) (
   input  logic                              clk,
   input  logic                              rst_n,
   opb_register_ppc2simulink_sync_if.slave   opb,
   input  logic [3:0][31:0]                  rd_words,
   output logic                              wr_en,
   output logic [1:0]                        wr_off
);

   opb_state_e  state_r;
   opb_state_e  state_nxt_s;
   logic        ack_r;
   logic        rnw_r;
   logic [1:0]  off_r;
   logic [31:0] dbus_r;
   logic [31:0] abus_s;
   logic [1:0]  off_s;
   logic [32:0] lo_diff_s;
   logic [32:0] hi_diff_s;
   logic        hit_s;

   assign abus_s = opb.OPB_ABus;
   assign off_s  = opb.OPB_ABus[28:29];

   // Window decode via borrow bits so a zero base does not fold to a constant.
   always_comb begin
      lo_diff_s = {1'b0, abus_s} - {1'b0, C_BASEADDR};
      hi_diff_s = {1'b0, C_HIGHADDR} - {1'b0, abus_s};
      hit_s     = opb.OPB_select & ~lo_diff_s[32] & ~hi_diff_s[32];
   end

   // Next-state logic; RECOVER deliberately ignores select.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (hit_s) begin
               state_nxt_s = ACK;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACK:     state_nxt_s = RECOVER;
         RECOVER: state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, ack and read data registered together so they appear in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         ack_r   <= 1'b0;
         dbus_r  <= 32'h00000000;
         rnw_r   <= 1'b0;
         off_r   <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         ack_r   <= (state_nxt_s == ACK);
         if ((state_nxt_s == ACK) && opb.OPB_RNW) begin
            dbus_r <= rd_words[off_s];
         end else begin
            dbus_r <= 32'h00000000;
         end
         if ((state_r == IDLE) && hit_s) begin
            rnw_r <= opb.OPB_RNW;
            off_r <= off_s;
         end else begin
            rnw_r <= rnw_r;
            off_r <= off_r;
         end
      end
   end

   assign opb.Sl_xferAck = ack_r;
   assign opb.Sl_DBus    = dbus_r;
   assign wr_en          = ack_r & ~rnw_r;
   assign wr_off         = off_r;

endmodule

// File: rtl/opb_register_ppc2simulink_sync.sv
// PowerPC-to-fabric control register on OPB with readback and write counter.
// Optional shadow/commit staging is compiled in with OPB_REG_SHADOW_COMMIT_EN.
module opb_register_ppc2simulink_sync
   import opb_reg_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR    = 32'h00000000,
   parameter logic [31:0] C_HIGHADDR    = 32'h000000FF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter string       C_FAMILY      = "virtex6",
   parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
   input  logic                              OPB_Clk,
   input  logic                              OPB_Rst_n,
   opb_register_ppc2simulink_sync_if.slave   opb,
   output logic [31:0]                       user_data_out,
   output logic                              user_data_valid
);

   localparam string unused_family = C_FAMILY;

   if ((C_OPB_DWIDTH != 32) || (C_OPB_AWIDTH != 32)) begin : g_bad_width
      $error("opb_register_ppc2simulink_sync supports only 32-bit OPB");
   end

   logic             wr_en_s;
   logic [1:0]       wr_off_s;
   logic [3:0][31:0] rd_words_s;
   logic             data_hit_s;
   logic [31:0]      data_r;
   logic [15:0]      wr_count_r;
   logic             valid_r;
   logic             unused_s;

   assign unused_s = opb.OPB_seqAddr;

   opb_slave_fsm #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR)
   ) u_fsm (
      .clk      (OPB_Clk),
      .rst_n    (OPB_Rst_n),
      .opb      (opb),
      .rd_words (rd_words_s),
      .wr_en    (wr_en_s),
      .wr_off   (wr_off_s)
   );

   assign data_hit_s = wr_en_s & (wr_off_s == OFF_DATA) & (|opb.OPB_BE);

`ifdef OPB_REG_SHADOW_COMMIT_EN
   logic [31:0] shadow_r;
   logic        commit_hit_s;

   // Commit flag is user bit 0, which is OPB data bit 31.
   assign commit_hit_s = wr_en_s & (wr_off_s == OFF_COMMIT) & opb.OPB_DBus[31];

   // Staged writes land in the shadow; only a commit reaches the fabric.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         shadow_r   <= C_RESET_VALUE;
         data_r     <= C_RESET_VALUE;
         wr_count_r <= 16'h0000;
         valid_r    <= 1'b0;
      end else begin
         if (data_hit_s) begin
            shadow_r <= be_merge(shadow_r, opb.OPB_DBus, opb.OPB_BE);
         end else begin
            shadow_r <= shadow_r;
         end
         if (commit_hit_s) begin
            data_r     <= shadow_r;
            wr_count_r <= wr_count_r + 16'h0001;
            valid_r    <= 1'b1;
         end else begin
            valid_r    <= 1'b0;
         end
      end
   end

   // Readback word table indexed by word offset.
   always_comb begin
      rd_words_s             = '0;
      rd_words_s[OFF_DATA]   = shadow_r;
      rd_words_s[OFF_STATUS] = {STATUS_SIG, wr_count_r};
   end
`else
   // DATA writes go straight to the fabric-facing register.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         data_r     <= C_RESET_VALUE;
         wr_count_r <= 16'h0000;
         valid_r    <= 1'b0;
      end else begin
         if (data_hit_s) begin
            data_r     <= be_merge(data_r, opb.OPB_DBus, opb.OPB_BE);
            wr_count_r <= wr_count_r + 16'h0001;
            valid_r    <= 1'b1;
         end else begin
            valid_r    <= 1'b0;
         end
      end
   end

   // Readback word table indexed by word offset.
   always_comb begin
      rd_words_s             = '0;
      rd_words_s[OFF_DATA]   = data_r;
      rd_words_s[OFF_STATUS] = {STATUS_SIG, wr_count_r};
   end
`endif

   assign user_data_out   = data_r;
   assign user_data_valid = valid_r;
   assign opb.Sl_errAck   = 1'b0;
   assign opb.Sl_retry    = 1'b0;
   assign opb.Sl_toutSup  = 1'b0;

endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
// Self-checking bench: vector table of bus transactions with a scoreboard queue,
// plus hand sequences for out-of-window, counter wrap and mid-ack reset.
module tb_opb_register_ppc2simulink_sync;

   localparam logic [31:0] BASE  = 32'h00001000;
   localparam logic [31:0] HIGH  = 32'h000010FF;
   localparam logic [31:0] RSTV  = 32'h12345678;

   typedef struct {
      logic        rnw;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [31:0] exp_user;
      logic        exp_valid;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic [31:0] user;
      logic        valid;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] user_data_out;
   logic        user_data_valid;
   int          checks_total;
   int          checks_pass;
   exp_t        sb_q[$];
   vec_t        vecs[18];

   opb_register_ppc2simulink_sync_if bus();

   opb_register_ppc2simulink_sync #(
      .C_BASEADDR    (BASE),
      .C_HIGHADDR    (HIGH),
      .C_OPB_AWIDTH  (32),
      .C_OPB_DWIDTH  (32),
      .C_FAMILY      ("virtex6"),
      .C_RESET_VALUE (RSTV)
   ) dut (
      .OPB_Clk         (clk),
      .OPB_Rst_n       (rst_n),
      .opb             (bus.slave),
      .user_data_out   (user_data_out),
      .user_data_valid (user_data_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) begin
         checks_pass++;
      end else begin
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      bus.OPB_ABus    = 32'h00000000;
      bus.OPB_BE      = 4'b0000;
      bus.OPB_DBus    = 32'h00000000;
      bus.OPB_RNW     = 1'b0;
      bus.OPB_select  = 1'b0;
      bus.OPB_seqAddr = 1'b0;
   endtask

   // One OPB transaction: expectation queued at drive, popped at the ack.
   task automatic txn(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic [31:0] exp_user, input logic exp_valid, input string name);
      exp_t e;
      int   n;
      e.rd = exp_rd; e.user = exp_user; e.valid = exp_valid;
      sb_q.push_back(e);
      @(negedge clk);
      bus.OPB_ABus   = addr;
      bus.OPB_BE     = be;
      bus.OPB_DBus   = wdata;
      bus.OPB_RNW    = rnw;
      bus.OPB_select = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.Sl_xferAck && n < 8);
      check({name, " ack_latency"}, 32'(n), 32'd1);
      e = sb_q.pop_front();
      check({name, " rd_data"}, bus.Sl_DBus, e.rd);
      bus.OPB_select = 1'b0;
      @(negedge clk);
      check({name, " ack_single"}, {31'd0, bus.Sl_xferAck}, 32'd0);
      check({name, " dbus_idle"}, bus.Sl_DBus, 32'd0);
      check({name, " valid"}, {31'd0, user_data_valid}, {31'd0, e.valid});
      check({name, " user"}, user_data_out, e.user);
      bus_idle();
      @(negedge clk);
      check({name, " valid_off"}, {31'd0, user_data_valid}, 32'd0);
   endtask

   initial begin
      checks_total = 0;
      checks_pass  = 0;
      bus_idle();
      rst_n = 1'b0;

      vecs[0]  = '{1'b0, BASE + 32'h0,  4'b1111, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b1};
      vecs[1]  = '{1'b1, BASE + 32'h4,  4'b1111, 32'h0,        32'hA5C30001, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, BASE + 32'h0,  4'b1111, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{1'b0, BASE + 32'h0,  4'b0001, 32'h000000AA, 32'h0,        32'hDEADBEAA, 1'b1};
      vecs[4]  = '{1'b0, BASE + 32'h0,  4'b0000, 32'hFFFFFFFF, 32'h0,        32'hDEADBEAA, 1'b0};
      vecs[5]  = '{1'b1, BASE + 32'h4,  4'b1111, 32'h0,        32'hA5C30002, 32'hDEADBEAA, 1'b0};
      vecs[6]  = '{1'b0, BASE + 32'h0,  4'b1000, 32'h11FFFFFF, 32'h0,        32'h11ADBEAA, 1'b1};
      vecs[7]  = '{1'b0, BASE + 32'h0,  4'b0110, 32'h00223300, 32'h0,        32'h112233AA, 1'b1};
      vecs[8]  = '{1'b0, BASE + 32'h4,  4'b1111, 32'h00000000, 32'h0,        32'h112233AA, 1'b0};
      vecs[9]  = '{1'b1, BASE + 32'h4,  4'b1111, 32'h0,        32'hA5C30004, 32'h112233AA, 1'b0};
      vecs[10] = '{1'b0, BASE + 32'h8,  4'b1111, 32'hFFFFFFFF, 32'h0,        32'h112233AA, 1'b0};
      vecs[11] = '{1'b1, BASE + 32'h8,  4'b1111, 32'h0,        32'h0,        32'h112233AA, 1'b0};
      vecs[12] = '{1'b0, BASE + 32'hC,  4'b1111, 32'hFFFFFFFF, 32'h0,        32'h112233AA, 1'b0};
      vecs[13] = '{1'b1, BASE + 32'hC,  4'b1111, 32'h0,        32'h0,        32'h112233AA, 1'b0};
      vecs[14] = '{1'b1, HIGH - 32'h3,  4'b1111, 32'h0,        32'h0,        32'h112233AA, 1'b0};
      vecs[15] = '{1'b0, BASE + 32'h10, 4'b1111, 32'h5A5A5A5A, 32'h0,        32'h5A5A5A5A, 1'b1};
      vecs[16] = '{1'b1, BASE + 32'hF0, 4'b1111, 32'h0,        32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0};
      vecs[17] = '{1'b1, BASE + 32'h4,  4'b1111, 32'h0,        32'hA5C30005, 32'h5A5A5A5A, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst user", user_data_out, RSTV);
      check("rst ack", {31'd0, bus.Sl_xferAck}, 32'd0);
      check("rst dbus", bus.Sl_DBus, 32'd0);
      check("rst valid", {31'd0, user_data_valid}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-rst user", user_data_out, RSTV);

      // Out-of-window reads are never acked
      bus.OPB_ABus = HIGH + 32'h4; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("oow-high ack", {31'd0, bus.Sl_xferAck}, 32'd0);
         check("oow-high dbus", bus.Sl_DBus, 32'd0);
      end
      bus.OPB_ABus = BASE - 32'h4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("oow-low ack", {31'd0, bus.Sl_xferAck}, 32'd0);
      end
      bus_idle();
      @(negedge clk);

`ifndef OPB_REG_SHADOW_COMMIT_EN
      for (int i = 0; i < 18; i++) begin
         txn(vecs[i].rnw, vecs[i].addr, vecs[i].be, vecs[i].wdata,
             vecs[i].exp_rd, vecs[i].exp_user, vecs[i].exp_valid, $sformatf("vec%0d", i));
      end
`else
      txn(1'b0, BASE,       4'b1111, 32'hCAFEF00D, 32'h0,        RSTV,         1'b0, "sh-wr");
      txn(1'b1, BASE,       4'b1111, 32'h0,        32'hCAFEF00D, RSTV,         1'b0, "sh-rd");
      txn(1'b1, BASE + 4,   4'b1111, 32'h0,        32'hA5C30000, RSTV,         1'b0, "sh-st0");
      txn(1'b0, BASE + 8,   4'b1111, 32'h0,        32'h0,        RSTV,         1'b0, "sh-nocommit");
      txn(1'b0, BASE + 8,   4'b1111, 32'h1,        32'h0,        32'hCAFEF00D, 1'b1, "sh-commit");
      txn(1'b1, BASE + 4,   4'b1111, 32'h0,        32'hA5C30001, 32'hCAFEF00D, 1'b0, "sh-st1");
`endif

      // Counter wrap from a forced 16'hFFFF
      @(negedge clk);
      force dut.wr_count_r = 16'hFFFF;
      #1;
      release dut.wr_count_r;
`ifndef OPB_REG_SHADOW_COMMIT_EN
      txn(1'b1, BASE + 4, 4'b1111, 32'h0, 32'hA5C3FFFF, 32'h5A5A5A5A, 1'b0, "wrap-pre");
      txn(1'b0, BASE,     4'b1111, 32'h0F0F0F0F, 32'h0, 32'h0F0F0F0F, 1'b1, "wrap-wr");
      txn(1'b1, BASE + 4, 4'b1111, 32'h0, 32'hA5C30000, 32'h0F0F0F0F, 1'b0, "wrap-post");
`else
      txn(1'b1, BASE + 4, 4'b1111, 32'h0, 32'hA5C3FFFF, 32'hCAFEF00D, 1'b0, "wrap-pre");
      txn(1'b0, BASE + 8, 4'b1111, 32'h1, 32'h0, 32'hCAFEF00D, 1'b1, "wrap-commit");
      txn(1'b1, BASE + 4, 4'b1111, 32'h0, 32'hA5C30000, 32'hCAFEF00D, 1'b0, "wrap-post");
`endif

      // Reset during the ACK cycle of a write aborts it
      begin
         int n;
         @(negedge clk);
         bus.OPB_ABus = BASE; bus.OPB_BE = 4'b1111; bus.OPB_DBus = 32'h55555555;
         bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!bus.Sl_xferAck && n < 8);
         check("abort ack_latency", 32'(n), 32'd1);
         rst_n = 1'b0;
         #1;
         check("abort ack drop", {31'd0, bus.Sl_xferAck}, 32'd0);
         check("abort dbus", bus.Sl_DBus, 32'd0);
         check("abort user", user_data_out, RSTV);
         bus_idle();
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort no valid", {31'd0, user_data_valid}, 32'd0);
            check("abort user hold", user_data_out, RSTV);
         end
      end
      txn(1'b1, BASE + 4, 4'b1111, 32'h0, 32'hA5C30000, RSTV, 1'b0, "abort status");
      txn(1'b1, BASE,     4'b1111, 32'h0, RSTV,         RSTV, 1'b0, "abort data");

      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

endmodule
